// File: rtl/rect_fill_fsm.sv
// rect_fill_fsm: fills an axis-aligned framebuffer rectangle one pixel per
// clock (solid colour or x-stripe), driving the VGA adapter x/y/colour/plot
// inputs, with a start/busy/done command handshake.
// Optional feature macro: RFILL_CLEAR_ON_RESET_EN (clears the full screen to
// colour 0 after reset before accepting commands).
module rect_fill_fsm #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [X_W-1:0]     x1,
    input  logic [Y_W-1:0]     y1,
    input  logic               mode,
    input  logic [COLOR_W-1:0] fill_color,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] color,
    output logic               plot,
    output logic               busy,
    output logic               done
);

`ifdef RFILL_CLEAR_ON_RESET_EN
    typedef enum logic [2:0] {IDLE, SETUP, FILL, FIN, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SETUP, FILL, FIN} state_t;
`endif

    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

    state_t             state;

    // command latched at acceptance
    logic [X_W-1:0]     xa, xb;
    logic [Y_W-1:0]     ya, yb_raw;
    logic               mode_q;
    logic [COLOR_W-1:0] fill_q;

    // ordered, clamped bounds used during the scan
    logic [X_W-1:0]     xr;
    logic [Y_W-1:0]     yt, yb;

    // clamp/order results and next scan position
    logic [X_W-1:0]     xac, xbc, sxl, sxr;
    logic [Y_W-1:0]     yac, ybc, syt, syb;
    logic [X_W-1:0]     nx;
    logic [Y_W-1:0]     ny;
    logic               last;

    // clamp the latched corners to the screen and order them
    always_comb begin
        xac = (32'(xa) >= SCREEN_W) ? X_MAX : xa;
        xbc = (32'(xb) >= SCREEN_W) ? X_MAX : xb;
        yac = (32'(ya) >= SCREEN_H) ? Y_MAX : ya;
        ybc = (32'(yb_raw) >= SCREEN_H) ? Y_MAX : yb_raw;
        sxl = (xac <= xbc) ? xac : xbc;
        sxr = (xac <= xbc) ? xbc : xac;
        syt = (yac <= ybc) ? yac : ybc;
        syb = (yac <= ybc) ? ybc : yac;
    end

    // column-major step from the pixel currently on the outputs
    always_comb begin
        last = (x == xr) && (y == yb);
        if (y == yb) begin
            nx = x + X_W'(1);
            ny = yt;
        end else begin
            nx = x;
            ny = y + Y_W'(1);
        end
    end

    // control FSM; x/y double as the scan counters
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef RFILL_CLEAR_ON_RESET_EN
            state <= CLEAR;
`else
            state <= IDLE;
`endif
            x     <= '0;
            y     <= '0;
            color <= '0;
            plot  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        xa     <= x0;
                        ya     <= y0;
                        xb     <= x1;
                        yb_raw <= y1;
                        mode_q <= mode;
                        fill_q <= fill_color;
                        busy   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    xr    <= sxr;
                    yt    <= syt;
                    yb    <= syb;
                    x     <= sxl;
                    y     <= syt;
                    color <= mode_q ? sxl[COLOR_W-1:0] : fill_q;
                    plot  <= 1'b1;
                    state <= FILL;
                end
                FILL: begin
                    if (last) begin
                        plot  <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        x     <= nx;
                        y     <= ny;
                        color <= mode_q ? nx[COLOR_W-1:0] : fill_q;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
`ifdef RFILL_CLEAR_ON_RESET_EN
                // full-screen clear reuses the FILL scan with fixed bounds
                CLEAR: begin
                    mode_q <= 1'b0;
                    fill_q <= '0;
                    xr     <= X_MAX;
                    yt     <= '0;
                    yb     <= Y_MAX;
                    x      <= '0;
                    y      <= '0;
                    color  <= '0;
                    plot   <= 1'b1;
                    busy   <= 1'b1;
                    state  <= FILL;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_fsm.sv
// tb_rect_fill_fsm: directed self-checking bench for rect_fill_fsm.
module tb_rect_fill_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic       mode;
    logic [2:0] fill_color;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       plot, busy, done;

    int total = 0;
    int bad   = 0;

    // capture of one command
    int px[$], py[$], pc[$];
    int first_i, last_i, done_i, ndone, busy1, maxx, maxy;

    rect_fill_fsm dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .mode(mode), .fill_color(fill_color),
        .x(x), .y(y), .color(color),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic set_cmd(input int ax, input int ay, input int bx, input int by,
                           input int m, input int c);
        x0 = 8'(ax); y0 = 7'(ay); x1 = 8'(bx); y1 = 7'(by);
        mode = 1'(m); fill_color = 3'(c);
    endtask

    // pulse (or hold) start and record plots until done; i counts cycles after acceptance
    task automatic run_cmd(input int budget, input bit hold, input bit disturb);
        px.delete(); py.delete(); pc.delete();
        first_i = -1; last_i = -1; done_i = -1; ndone = 0; busy1 = 0;
        maxx = 0; maxy = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (i == 1) begin
                busy1 = int'(busy);
                if (!hold) start = 1'b0;
                if (disturb) set_cmd(50, 50, 60, 60, 1, 0);
            end
            if (plot) begin
                if (first_i < 0) first_i = i;
                last_i = i;
                px.push_back(int'(x)); py.push_back(int'(y)); pc.push_back(int'(color));
                if (int'(x) > maxx) maxx = int'(x);
                if (int'(y) > maxy) maxy = int'(y);
            end
            if (done) begin
                ndone++;
                done_i = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0;
        set_cmd(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        total++; if ({x, y, color} !== 18'd0) begin bad++;
            $display("FAIL reset_xyc: got x=%0d y=%0d c=%0d want 0 0 0", x, y, color); end
        total++; if ({plot, busy, done} !== 3'b000) begin bad++;
            $display("FAIL reset_ctrl: got plot/busy/done=%b want 000", {plot, busy, done}); end
        reset = 1'b0;
        @(negedge clk);
        total++; if ({plot, busy, done} !== 3'b000) begin bad++;
            $display("FAIL idle_ctrl: got plot/busy/done=%b want 000", {plot, busy, done}); end
    endtask

    task automatic test_solid;
        int ex[6] = '{10, 10, 11, 11, 12, 12};
        int ey[6] = '{20, 21, 20, 21, 20, 21};
        set_cmd(10, 20, 12, 21, 0, 5);
        run_cmd(40, 1'b0, 1'b0);
        total++; if (busy1 !== 1) begin bad++;
            $display("FAIL solid_busy: got %0d want 1", busy1); end
        total++; if (first_i !== 2) begin bad++;
            $display("FAIL solid_latency: got %0d want 2", first_i); end
        total++; if (px.size() !== 6 || last_i - first_i + 1 !== 6) begin bad++;
            $display("FAIL solid_count: got %0d plots span %0d want 6", px.size(), last_i - first_i + 1); end
        for (int k = 0; k < 6 && k < px.size(); k++) begin
            total++; if (px[k] !== ex[k] || py[k] !== ey[k] || pc[k] !== 5) begin bad++;
                $display("FAIL solid_pix%0d: got (%0d,%0d) c=%0d want (%0d,%0d) c=5",
                         k, px[k], py[k], pc[k], ex[k], ey[k]); end
        end
        total++; if (done_i !== 8) begin bad++;
            $display("FAIL solid_done: got cycle %0d want 8", done_i); end
        total++; if (busy !== 1'b0) begin bad++;
            $display("FAIL solid_busy_fin: got %b want 0", busy); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++;
            $display("FAIL solid_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_reverse;
        int k = 0;
        set_cmd(5, 9, 3, 7, 1, 0);
        run_cmd(40, 1'b0, 1'b0);
        total++; if (px.size() !== 9 || done_i !== 11) begin bad++;
            $display("FAIL rev_count: got %0d plots done@%0d want 9 done@11", px.size(), done_i); end
        for (int cx = 3; cx <= 5; cx++) begin
            for (int cy = 7; cy <= 9; cy++) begin
                if (k < px.size()) begin
                    total++; if (px[k] !== cx || py[k] !== cy || pc[k] !== cx) begin bad++;
                        $display("FAIL rev_pix%0d: got (%0d,%0d) c=%0d want (%0d,%0d) c=%0d",
                                 k, px[k], py[k], pc[k], cx, cy, cx); end
                end
                k++;
            end
        end
    endtask

    task automatic test_clamp;
        int ex[4] = '{158, 158, 159, 159};
        int ey[4] = '{118, 119, 118, 119};
        set_cmd(158, 118, 200, 127, 0, 2);
        run_cmd(40, 1'b0, 1'b0);
        total++; if (px.size() !== 4 || ndone !== 1) begin bad++;
            $display("FAIL clamp_count: got %0d plots %0d done want 4 1", px.size(), ndone); end
        total++; if (maxx > 159 || maxy > 119) begin bad++;
            $display("FAIL clamp_range: got max (%0d,%0d) want <= (159,119)", maxx, maxy); end
        for (int k = 0; k < 4 && k < px.size(); k++) begin
            total++; if (px[k] !== ex[k] || py[k] !== ey[k] || pc[k] !== 2) begin bad++;
                $display("FAIL clamp_pix%0d: got (%0d,%0d) c=%0d want (%0d,%0d) c=2",
                         k, px[k], py[k], pc[k], ex[k], ey[k]); end
        end
    endtask

    task automatic test_back_to_back;
        int ex[4] = '{1, 1, 2, 2};
        int ey[4] = '{1, 2, 1, 2};
        set_cmd(1, 1, 2, 2, 0, 6);
        run_cmd(40, 1'b1, 1'b1);
        total++; if (px.size() !== 4 || ndone !== 1 || done_i !== 6) begin bad++;
            $display("FAIL b2b_count: got %0d plots done@%0d want 4 done@6", px.size(), done_i); end
        for (int k = 0; k < 4 && k < px.size(); k++) begin
            total++; if (px[k] !== ex[k] || py[k] !== ey[k] || pc[k] !== 6) begin bad++;
                $display("FAIL b2b_pix%0d: got (%0d,%0d) c=%0d want (%0d,%0d) c=6",
                         k, px[k], py[k], pc[k], ex[k], ey[k]); end
        end
        @(negedge clk);
        total++; if (busy !== 1'b0 || plot !== 1'b0) begin bad++;
            $display("FAIL b2b_idle: got busy=%b plot=%b want 0 0", busy, plot); end
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++;
            $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int extra = 0;
        bit hit = 1'b0;
        set_cmd(0, 0, 3, 4, 0, 7);
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (plot) n++;
            if (n == 3) begin hit = 1'b1; reset = 1'b1; break; end
        end
        total++; if (!hit) begin bad++;
            $display("FAIL mid_third_plot: got %0d plots want 3", n); end
        @(negedge clk);
        reset = 1'b0;
        total++; if ({plot, busy, done} !== 3'b000 || {x, y, color} !== 18'd0) begin bad++;
            $display("FAIL mid_reset_out: got p/b/d=%b x=%0d y=%0d c=%0d want 000 0 0 0",
                     {plot, busy, done}, x, y, color); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (plot || done || busy) extra++;
        end
        total++; if (extra !== 0) begin bad++;
            $display("FAIL mid_no_done: got %0d active cycles want 0", extra); end
    endtask

    initial begin
        test_reset;
        test_solid;
        test_reverse;
        test_clamp;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
